keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 50000, meaning the clock cycles each column is driven (dwell); legal values are 2 or more.
REQ-002 SHALL provide parameter DEBOUNCE, default 4, meaning the consecutive identical scan frames needed to accept a press or release; legal range is 1..15.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port row  input  4  keypad rows, active-low, externally pulled up; row[r]=0 means a key in row r of the driven column is closed.
REQ-006 SHALL have port col  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port clr  input  1  synchronous clear of value.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when a debounced new press is accepted.
REQ-009 SHALL have port key_code  output  4  code of the last accepted key.
REQ-010 SHALL have port key_down  output  1  debounced level, high while the accepted key is held.
REQ-011 SHALL have port value  output  32  hex digit shift register (eight nibbles) intended for the segment display.

Function
REQ-012 Key code SHALL be row_index*4 + col_index (0..15); col_index c corresponds to col[c]=0.
REQ-013 Column sequence SHALL be 1110, 1101, 1011, 0111, then wrap to 1110, advancing one step every SCAN_DIV cycles.
REQ-014 Dwell counter SHALL count 0..SCAN_DIV-1. Rows SHALL be sampled only at count SCAN_DIV-1. col SHALL change on the following edge.
REQ-015 A frame SHALL be the four consecutive column dwells starting at column 0. Frame length is 4*SCAN_DIV cycles.
REQ-016 Each frame SHALL produce one result:
- NONE: no low row bits in any sample.
- SINGLE(code): exactly one closed key in the frame.
- MULTI: two or more closed keys, in the same or different columns.
REQ-017 At frame end, stable count handling:
- If the result equals the previous frame result, the stable count SHALL increment, saturating at DEBOUNCE.
- Otherwise the count SHALL load 1 and the previous result SHALL be updated.
REQ-018 Debounce FSM SHALL have states UP and DOWN; reset state is UP.
REQ-019 In UP, when the stable count reaches DEBOUNCE with result SINGLE(k), the next edge SHALL:
- enter DOWN;
- set key_down=1 and key_code=k;
- pulse key_valid for exactly one cycle;
- load value={value[27:0],k}.
REQ-020 In DOWN, when the stable count reaches DEBOUNCE with result NONE, the FSM SHALL enter UP and set key_down=0, with no key_valid.
REQ-021 MULTI and changes between SINGLE codes SHALL cause no transition in either state; no new press is accepted until a debounced release.
REQ-022 key_valid SHALL assert on the cycle after the row sample that completes the DEBOUNCE-th identical frame.
REQ-023 value shifting SHALL discard the top nibble; no digit count or overflow flag.
REQ-024 When clr=1, value SHALL be 0 on the next edge. clr SHALL take priority over a coincident shift. key_valid, key_code and key_down SHALL be unaffected by clr.
REQ-025 row SHALL pass through a two-flop synchronizer before sampling; its 2-cycle delay SHALL be absorbed by the dwell (SCAN_DIV of 2 or more).

Reset
REQ-026 When rst=1, the next edge SHALL set:
- col=1110, dwell count=0, column index=0;
- FSM=UP, stable count=0, previous result=NONE;
- key_valid=0, key_code=0, key_down=0, value=0;
- synchronizer flops to 1111.
REQ-027 rst SHALL override clr and any frame-end event in the same cycle. Reset mid-frame SHALL discard the partial frame; a held key SHALL need DEBOUNCE full frames after reset to be accepted.

Verification (SCAN_DIV=4, DEBOUNCE=3, frame=16 cycles; bench drives row[r]=0 when col[c]=0 and key (r,c) held)
REQ-028 Hold key r1,c2 for 6 frames -> exactly one key_valid pulse, key_code=6, key_down=1, value=0x00000006; after release for 3 frames -> key_down=0, no pulse.
REQ-029 Key 5 alternates pressed/released every frame for 8 frames -> no key_valid, value stays 0.
REQ-030 Press then release keys 1,2,...,9 in order -> value=0x23456789 after the ninth press, with nine key_valid pulses in total.
REQ-031 Hold keys 0 and 15 together for 5 frames -> no key_valid, key_down=0; then release 15 while holding 0 for 3 frames -> one pulse, key_code=0.
REQ-032 Assert clr in the same cycle as a key_valid for code 0xA, with value=0x12 beforehand -> value=0 and the key_valid pulse still occurs.
REQ-033 Assert rst for one cycle in frame 2 of a held key 3 -> all outputs take reset values and col=1110; key_valid follows exactly 3 full frames after reset release.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame-based debounce and a hex digit shift register.
module keypad_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        clr,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_down,
    output logic [31:0] value
);
    localparam int CW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;
    typedef enum logic {UP, DOWN} state_t;

    logic [3:0]    r_sync1, r_sync2;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_col_idx;
    res_t          r_acc_type, r_prev_type;
    logic [3:0]    r_acc_code, r_prev_code;
    logic [3:0]    r_stable;
    state_t        r_state;
    logic          r_key_valid, r_key_down;
    logic [3:0]    r_key_code;
    logic [31:0]   r_value;

    logic       w_sample, w_frame_end, w_row_any, w_row_many, w_same, w_settled, w_accept, w_release;
    logic [3:0] w_closed, w_res_code, w_stable_nxt;
    logic [1:0] w_row_idx;
    res_t       w_res_type;

    assign w_sample    = r_cnt == CW'(SCAN_DIV - 1);
    assign w_frame_end = w_sample && r_col_idx == 2'd3;
    assign w_closed    = ~r_sync2;
    assign w_row_any   = |w_closed;
    assign w_row_many  = (w_closed & (w_closed - 4'd1)) != 4'd0;
    assign w_row_idx   = w_closed[0] ? 2'd0 : w_closed[1] ? 2'd1 : w_closed[2] ? 2'd2 : 2'd3;
    // Fold this column's sample into the frame accumulated so far.
    assign w_res_type  = !w_row_any ? r_acc_type :
                         (w_row_many || r_acc_type != RES_NONE) ? RES_MULTI : RES_SINGLE;
    assign w_res_code  = w_row_any ? {w_row_idx, r_col_idx} : r_acc_code;
    assign w_same      = w_res_type == r_prev_type && (w_res_type != RES_SINGLE || w_res_code == r_prev_code);
    assign w_stable_nxt = !w_same ? 4'd1 : (r_stable == 4'(DEBOUNCE)) ? r_stable : r_stable + 4'd1;
    assign w_settled   = w_frame_end && w_stable_nxt == 4'(DEBOUNCE);
    assign w_accept    = w_settled && r_state == UP && w_res_type == RES_SINGLE;
    assign w_release   = w_settled && r_state == DOWN && w_res_type == RES_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 4'hF;
            r_sync2     <= 4'hF;
            r_cnt       <= '0;
            r_col_idx   <= 2'd0;
            r_acc_type  <= RES_NONE;
            r_acc_code  <= 4'd0;
            r_prev_type <= RES_NONE;
            r_prev_code <= 4'd0;
            r_stable    <= 4'd0;
            r_state     <= UP;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
            r_key_code  <= 4'd0;
            r_value     <= 32'd0;
        end else begin
            r_sync1     <= row;
            r_sync2     <= r_sync1;
            r_cnt       <= w_sample ? '0 : r_cnt + 1'b1;
            r_key_valid <= w_accept;
            r_value     <= clr ? 32'd0 : w_accept ? {r_value[27:0], w_res_code} : r_value;
            if (w_sample) begin
                r_col_idx  <= r_col_idx + 2'd1;
                r_acc_type <= w_frame_end ? RES_NONE : w_res_type;
                r_acc_code <= w_res_code;
            end
            if (w_frame_end) begin
                r_stable    <= w_stable_nxt;
                r_prev_type <= w_res_type;
                r_prev_code <= w_res_code;
            end
            if (w_accept) begin
                r_state    <= DOWN;
                r_key_down <= 1'b1;
                r_key_code <= w_res_code;
            end else if (w_release) begin
                r_state    <= UP;
                r_key_down <= 1'b0;
            end
        end
    end

    assign col       = ~(4'b0001 << r_col_idx);
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_down  = r_key_down;
    assign value     = r_value;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: randomized and directed keypad scanning against a frame-level reference model with a pulse scoreboard.
module tb_keypad_scan;
    localparam int SD = 4, DB = 3, FL = 4 * SD;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1, clr = 1'b0;
    logic [3:0]  row, col, key_code;
    logic        key_valid, key_down;
    logic [31:0] value;
    logic [15:0] mask = 16'h0;

    int n_cmp = 0, n_bad = 0, n_pulses = 0;
    exp_t q[$];
    int m_prev_type, m_prev_code, m_stable;
    bit m_down;
    logic [3:0]  m_code;
    logic [31:0] m_value;

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .clr(clr),
        .key_valid(key_valid), .key_code(key_code), .key_down(key_down), .value(value)
    );

    always #5 clk = ~clk;

    // Key matrix: a held key (r,c) pulls row r low while column c is driven.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col[c] && mask[r*4+c]) row[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && key_valid) begin
            n_pulses++;
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got code %h expected no pulse at %0t", key_code, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_code", {28'd0, key_code}, {28'd0, e.code});
                chk("pulse_value", value, e.val);
                chk("pulse_down", {31'd0, key_down}, 32'd1);
            end
        end
    end

    task automatic model_reset();
        m_prev_type = 0;
        m_prev_code = 0;
        m_stable = 0;
        m_down = 0;
        m_code = 4'd0;
        m_value = 32'd0;
    endtask

    // One frame as a whole: classify the held set, then apply debounce rules.
    task automatic model_frame(input logic [15:0] m, input bit c);
        int pc, t, code;
        pc = $countones(m);
        t = (pc == 0) ? 0 : (pc == 1) ? 1 : 2;
        code = 0;
        for (int i = 0; i < 16; i++) if (m[i]) code = i;
        if (t == m_prev_type && (t != 1 || code == m_prev_code)) m_stable = (m_stable < DB) ? m_stable + 1 : DB;
        else begin
            m_stable = 1;
            m_prev_type = t;
            m_prev_code = code;
        end
        if (!m_down && m_stable == DB && t == 1) begin
            m_down = 1;
            m_code = 4'(code);
            m_value = c ? 32'd0 : {m_value[27:0], 4'(code)};
            q.push_back('{code: 4'(code), val: m_value});
        end else begin
            if (c) m_value = 32'd0;
            if (m_down && m_stable == DB && t == 0) m_down = 0;
        end
    endtask

    task automatic run_frame(input logic [15:0] m, input bit c);
        mask = m;
        for (int i = 0; i < FL; i++) begin
            clr = c && i == FL - 1;
            @(posedge clk);
            #1;
        end
        clr = 1'b0;
        model_frame(m, c);
        chk("frame_key_down", {31'd0, key_down}, {31'd0, m_down});
        chk("frame_key_code", {28'd0, key_code}, {28'd0, m_code});
        chk("frame_value", value, m_value);
    endtask

    task automatic do_reset(input int partial);
        repeat (partial) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_col", {28'd0, col}, 32'hE);
        chk("rst_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_down", {31'd0, key_down}, 32'd0);
        chk("rst_code", {28'd0, key_code}, 32'd0);
        chk("rst_value", value, 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int p0, len, kind, a, b;
        logic [15:0] m;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset(0);

        repeat (6) run_frame(16'h1 << 6, 1'b0);
        chk("hold6_value", value, 32'h6);
        chk("hold6_down", {31'd0, key_down}, 32'd1);
        chk("hold6_pulses", n_pulses, 1);
        repeat (3) run_frame(16'h0, 1'b0);
        chk("release_down", {31'd0, key_down}, 32'd0);
        chk("release_pulses", n_pulses, 1);

        do_reset(3);
        p0 = n_pulses;
        for (int i = 0; i < 8; i++) run_frame((i % 2 == 0) ? 16'h1 << 5 : 16'h0, 1'b0);
        chk("bounce_pulses", n_pulses, p0);
        chk("bounce_value", value, 32'h0);

        do_reset(5);
        p0 = n_pulses;
        for (int k = 1; k <= 9; k++) begin
            repeat (DB) run_frame(16'h1 << k, 1'b0);
            repeat (DB) run_frame(16'h0, 1'b0);
        end
        chk("seq_value", value, 32'h23456789);
        chk("seq_pulses", n_pulses - p0, 9);

        do_reset(2);
        p0 = n_pulses;
        repeat (5) run_frame(16'h8001, 1'b0);
        chk("multi_down", {31'd0, key_down}, 32'd0);
        chk("multi_pulses", n_pulses, p0);
        repeat (3) run_frame(16'h0001, 1'b0);
        run_frame(16'h0, 1'b0);
        chk("multi_then0_pulses", n_pulses - p0, 1);
        chk("multi_then0_code", {28'd0, key_code}, 32'd0);

        do_reset(4);
        for (int k = 1; k <= 2; k++) begin
            repeat (DB) run_frame(16'h1 << k, 1'b0);
            repeat (DB) run_frame(16'h0, 1'b0);
        end
        chk("pre_clr_value", value, 32'h12);
        p0 = n_pulses;
        run_frame(16'h1 << 10, 1'b0);
        run_frame(16'h1 << 10, 1'b0);
        run_frame(16'h1 << 10, 1'b1);
        run_frame(16'h0, 1'b0);
        chk("clr_value", value, 32'h0);
        chk("clr_pulses", n_pulses - p0, 1);
        chk("clr_code", {28'd0, key_code}, 32'hA);

        do_reset(2);
        run_frame(16'h1 << 3, 1'b0);
        mask = 16'h1 << 3;
        do_reset(6);
        p0 = n_pulses;
        repeat (2) run_frame(16'h1 << 3, 1'b0);
        chk("rst_hold_pulses", n_pulses, p0);
        chk("rst_hold_down", {31'd0, key_down}, 32'd0);
        run_frame(16'h1 << 3, 1'b0);
        chk("rst_hold_down3", {31'd0, key_down}, 32'd1);
        run_frame(16'h0, 1'b0);
        chk("rst_hold_pulse3", n_pulses - p0, 1);

        do_reset(3);
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 3);
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            m = (kind == 0) ? 16'h0 : (kind == 3) ? ((16'h1 << a) | (16'h1 << b)) : (16'h1 << a);
            len = $urandom_range(1, 5);
            for (int f = 0; f < len; f++) run_frame(m, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 14) == 0) do_reset($urandom_range(2, 14));
        end

        mask = 16'h0;
        repeat (20) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
